// File: rtl/cordic_result_fifo.sv
// Result buffer at the tail of the CORDIC pipeline: a first-word-fall-through FIFO
// for {x,y,z} results, with credit tracking so the feeder never overruns it.
module cordic_result_fifo #(
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_in,
    input  logic          valid_in,
    input  logic [15:0]   x_in,
    input  logic [15:0]   y_in,
    input  logic [15:0]   z_in,
    output logic          can_issue,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_x,
    output logic [15:0]   out_y,
    output logic [15:0]   out_z,
    output logic [CW-1:0] level,
    output logic          overflow,
    input  logic          clear_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [47:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] inflight_r;
    logic          overflow_r;

    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic [CW-1:0] count_next_s;
    logic [CW-1:0] inflight_next_s;
    logic [CW:0]   credit_sum_s;
    logic [47:0]   head_s;

    // Handshake decode, next-state counters and output presentation
    always_comb begin
        pop_s           = (count_r != {CW{1'b0}}) && out_ready;
        push_s          = valid_in && ((count_r < FULL_C) || pop_s);
        drop_s          = valid_in && !push_s;
        count_next_s    = count_r;
        inflight_next_s = inflight_r;
        head_s          = mem_r[rd_ptr_r];

        if (push_s && !pop_s) begin
            count_next_s = count_r + CW'(1'b1);
        end else if (!push_s && pop_s) begin
            count_next_s = count_r - CW'(1'b1);
        end else begin
            count_next_s = count_r;
        end

        // In-flight credits saturate at both ends; simultaneous issue and result cancel
        case ({issue_in, valid_in})
            2'b10: begin
                if (inflight_r != FULL_C) begin
                    inflight_next_s = inflight_r + CW'(1'b1);
                end else begin
                    inflight_next_s = inflight_r;
                end
            end
            2'b01: begin
                if (inflight_r != {CW{1'b0}}) begin
                    inflight_next_s = inflight_r - CW'(1'b1);
                end else begin
                    inflight_next_s = inflight_r;
                end
            end
            default: inflight_next_s = inflight_r;
        endcase

        credit_sum_s = {1'b0, count_r} + {1'b0, inflight_r};
        can_issue    = credit_sum_s < {1'b0, FULL_C};
        out_valid    = count_r != {CW{1'b0}};
        level        = count_r;
        overflow     = overflow_r;

        if (out_valid) begin
            out_x = head_s[47:32];
            out_y = head_s[31:16];
            out_z = head_s[15:0];
        end else begin
            out_x = 16'h0000;
            out_y = 16'h0000;
            out_z = 16'h0000;
        end
    end

    // Pointer, occupancy, credit and sticky overflow state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            inflight_r <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r    <= count_next_s;
            inflight_r <= inflight_next_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clear_ovf) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Storage is left unreset; reads are gated by out_valid
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {x_in, y_in, z_in};
        end
    end

endmodule

// File: tb/tb_cordic_result_fifo.sv
// Self-checking bench for cordic_result_fifo: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_cordic_result_fifo;

    localparam int DEPTH = 16;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          issue_in = 1'b0;
    logic          valid_in = 1'b0;
    logic [15:0]   x_in = 16'h0000;
    logic [15:0]   y_in = 16'h0000;
    logic [15:0]   z_in = 16'h0000;
    logic          can_issue;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   out_x;
    logic [15:0]   out_y;
    logic [15:0]   out_z;
    logic [CW-1:0] level;
    logic          overflow;
    logic          clear_ovf = 1'b0;

    cordic_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .issue_in(issue_in), .valid_in(valid_in),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .can_issue(can_issue),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
        .out_y(out_y), .out_z(out_z), .level(level), .overflow(overflow),
        .clear_ovf(clear_ovf)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents, outstanding credits, sticky overflow
    logic [47:0] m_q[$];
    int          m_inf = 0;
    bit          m_ovf = 1'b0;
    int          m_pops = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_can_issue();
        return (m_q.size() + m_inf) < DEPTH;
    endfunction

    task automatic compare_all();
        logic [47:0] h;
        h = (m_q.size() != 0) ? m_q[0] : 48'h0;
        check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        check("out_x", 64'(out_x), 64'(h[47:32]));
        check("out_y", 64'(out_y), 64'(h[31:16]));
        check("out_z", 64'(out_z), 64'(h[15:0]));
        check("level", 64'(level), 64'(m_q.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("can_issue", 64'(can_issue), 64'(m_can_issue()));
    endtask

    task automatic step(input bit iss, input bit vld, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] z,
                        input bit rdy, input bit clr);
        bit pop;
        bit push;
        issue_in = iss; valid_in = vld; x_in = x; y_in = y; z_in = z;
        out_ready = rdy; clear_ovf = clr;
        @(posedge clk);
        pop  = (m_q.size() != 0) && rdy;
        push = vld && ((m_q.size() < DEPTH) || pop);
        if (pop) begin
            void'(m_q.pop_front());
            m_pops++;
        end
        if (push) m_q.push_back({x, y, z});
        if (vld && !push) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (iss && !vld && m_inf < DEPTH) m_inf++;
        else if (vld && !iss && m_inf > 0) m_inf--;
        @(negedge clk);
        issue_in = 1'b0; valid_in = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_q.delete();
        m_inf = 0;
        m_ovf = 1'b0;
        compare_all();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_level", 64'(level), 64'(0));
        check("rst_can_issue", 64'(can_issue), 64'(1'b1));
        check("rst_overflow", 64'(overflow), 64'(1'b0));
        check("rst_out_x", 64'(out_x), 64'(16'h0000));
        reset = 1'b0;

        // Single push then pop
        step(1'b0, 1'b1, 16'h4DBA, 16'h0000, 16'h0003, 1'b0, 1'b0);
        check("single_x", 64'(out_x), 64'(16'h4DBA));
        check("single_level", 64'(level), 64'(1));
        step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
        check("single_pop_valid", 64'(out_valid), 64'(1'b0));
        check("single_pop_x", 64'(out_x), 64'(16'h0000));

        // Fill, overflow, ordered drain, clear
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 16'(i), 16'(i + 1), 16'(i + 2), 1'b0, 1'b0);
        check("fill_level", 64'(level), 64'(DEPTH));
        step(1'b0, 1'b1, 16'd99, 16'h0, 16'h0, 1'b0, 1'b0);
        check("ovf_set", 64'(overflow), 64'(1'b1));
        check("ovf_level", 64'(level), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 64'(out_x), 64'(i));
            step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
        end
        check("drain_empty", 64'(out_valid), 64'(1'b0));
        step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        check("ovf_clear", 64'(overflow), 64'(1'b0));

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 16'(i + 100), 16'h0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h7777, 16'h1111, 16'h2222, 1'b1, 1'b0);
        check("fullpp_level", 64'(level), 64'(DEPTH));
        check("fullpp_ovf", 64'(overflow), 64'(1'b0));
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check("fullpp_last", 64'(out_x), 64'(16'h7777));
            step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
        end

        // Credits
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check("credit_before_last", 64'(can_issue), 64'(1'b1));
            step(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        end
        check("credit_exhausted", 64'(can_issue), 64'(1'b0));
        step(1'b0, 1'b1, 16'h0123, 16'h0, 16'h0, 1'b0, 1'b0);
        check("credit_after_result", 64'(can_issue), 64'(1'b0));
        step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
        check("credit_after_pop", 64'(can_issue), 64'(1'b1));

        // Streaming with 16-cycle pipeline latency, ready toggling
        do_reset();
        begin
            int due[$];
            int issued = 0;
            int delivered = 0;
            int pops0 = m_pops;
            for (int cyc = 0; cyc < 600 && (m_pops - pops0) < 40; cyc++) begin
                bit iss;
                bit vld;
                vld = (due.size() != 0) && (due[0] == cyc);
                if (vld) void'(due.pop_front());
                iss = (issued < 40) && m_can_issue();
                if (iss) begin
                    due.push_back(cyc + 16);
                    issued++;
                end
                step(iss, vld, 16'(delivered), ~16'(delivered), 16'(delivered * 3),
                     (cyc % 2) == 0, 1'b0);
                if (vld) delivered++;
                check("stream_level_bound", 64'(level <= CW'(DEPTH)), 64'(1'b1));
            end
            check("stream_all_out", 64'(m_pops - pops0), 64'(40));
            check("stream_no_ovf", 64'(overflow), 64'(1'b0));
        end

        // Asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'(i + 7), 16'h0, 16'h0, 1'b0, 1'b0);
        check("pre_arst_level", 64'(level), 64'(5));
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'(1'b0));
        check("arst_level", 64'(level), 64'(0));
        check("arst_can_issue", 64'(can_issue), 64'(1'b1));
        m_q.delete();
        m_inf = 0;
        m_ovf = 1'b0;
        #1 reset = 1'b0;
        step(1'b0, 1'b1, 16'hABCD, 16'h0001, 16'h0002, 1'b0, 1'b0);
        check("post_arst_x", 64'(out_x), 64'(16'hABCD));
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        check("post_arst_credit", 64'(can_issue), 64'(1'b0));

        // Random traffic including drops and clears
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 3) == 0, ($urandom % 3) == 0, 16'($urandom), 16'($urandom),
                 16'($urandom), ($urandom % 2) == 0, ($urandom % 16) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_result_fifo.md
# cordic_result_fifo

Output buffer at the tail of the CORDIC rotation pipeline. Captures the x/y/z results emitted by the final pipeline stage, which cannot be stalled, into a first-word-fall-through FIFO. Presents them to the consumer over a valid/ready handshake. Issues credits to the pipeline feeder so that an angle enters the pipeline only when a FIFO slot is guaranteed for its result.

## Interface

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥ 2.
- CW, $clog2(DEPTH)+1, width of the occupancy and in-flight counters; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- issue_in  input  1  pulse: feeder launched one angle into the pipeline this cycle.
- valid_in  input  1  result strobe from the last pipeline stage.
- x_in  input  16  final-stage x (cosine term), two's complement.
- y_in  input  16  final-stage y (sine term), two's complement.
- z_in  input  16  final-stage residual angle, two's complement.
- can_issue  output  1  feeder may assert issue_in this cycle.
- out_valid  output  1  head entry is available.
- out_ready  input  1  consumer accepts the head entry when out_valid is also high.
- out_x  output  16  head-entry x; 0 when empty.
- out_y  output  16  head-entry y; 0 when empty.
- out_z  output  16  head-entry z; 0 when empty.
- level  output  CW  registered occupancy, 0..DEPTH.
- overflow  output  1  sticky: a result was dropped.
- clear_ovf  input  1  synchronous clear of overflow.

## Operation

- Storage: DEPTH × 48-bit entries {x,y,z}. Write pointer wr_ptr and read pointer rd_ptr are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH. count is CW bits.
- push = valid_in && (count < DEPTH || pop).
- pop = out_valid && out_ready.
- count_next = count + push − pop.
- Full with simultaneous pop: the write is accepted and count stays at DEPTH.
- valid_in while count == DEPTH and no pop: the entry is dropped, no pointer moves, and overflow is set on the next edge.
- overflow: set on a drop, cleared by clear_ovf. If both happen in the same cycle, set wins.
- out_valid = (count != 0). out_x/y/z = mem[rd_ptr] when out_valid, otherwise 0, combinationally from registers.
- Push to an empty FIFO does not bypass; the data becomes visible the cycle after the write.
- Pop while empty: ignored, since out_valid is low.
- In-flight tracking: counter inflight (CW bits).
  - issue_in alone: +1.
  - valid_in alone: −1.
  - both in the same cycle: unchanged.
  - valid_in at inflight == 0 holds at 0 (saturating) and does not affect the FIFO path.
  - issue_in at inflight == DEPTH holds at DEPTH.
- can_issue = (count + inflight) < DEPTH, evaluated from registered values at CW+1-bit width. The feeder must honour it; issue_in while can_issue is low is still counted.
- level = count.

## Timing

- Reset values:
  - count, inflight, wr_ptr, rd_ptr = 0
  - out_valid = 0
  - out_x/out_y/out_z = 0
  - level = 0
  - overflow = 0
  - can_issue = 1
  - memory contents need not be cleared, because the output is gated by out_valid.
- Write latency: valid_in sampled at edge N gives out_valid = 1 with the data after edge N. This is one cycle.
- Pop: out_ready && out_valid at edge N advances rd_ptr, and the next entry (or empty) is visible after edge N.
- Throughput: one push and one pop per cycle, sustained.
- can_issue reflects the state after the most recent edge. It does not include issue_in in the current cycle. The feeder issues at most one angle per cycle, so an issue at can_issue = 1 never causes an overflow.
- Reset mid-operation: all entries and credits are discarded asynchronously. Results still in the pipeline after reset release are accepted as fresh pushes, with inflight saturating at 0.

## Test plan

- Reset, then single push: valid_in = 1 with x = 16'h4DBA, y = 16'h0000, z = 16'h0003. After the next edge, out_valid = 1, out_x = 16'h4DBA, level = 1. With out_ready = 1 for one cycle: out_valid = 0, out_x = 0, level = 0.
- Fill: with DEPTH = 16, push 16 entries with x = 0..15 while out_ready = 0, giving level = 16. A 17th valid_in (x = 99) sets overflow = 1 and leaves level = 16. Draining then yields x = 0..15 in order with no 99. Pulse clear_ovf and check overflow = 0.
- Full with simultaneous push and pop: from level = 16, valid_in with x = 16'h7777 and out_ready = 1 in the same cycle gives level = 16, overflow = 0, and 16'h7777 emerges last.
- Credits: from empty, pulse issue_in 16 times with no valid_in. can_issue falls to 0 after the 16th pulse. One valid_in keeps can_issue = 0 (count 1 + inflight 15 = 16). One pop brings can_issue back to 1.
- Pointer wrap under streaming: issue 40 angles, with valid_in 16 cycles after each issue_in and out_ready toggling 1,0,1,0. Check that all 40 results emerge in order, overflow never sets, and level ≤ 16 throughout.
- Asynchronous reset with level = 5 and inflight = 3: out_valid drops and level = 0 without waiting for a clock edge. A post-reset valid_in is accepted and leaves inflight = 0.
